div_repsub: RTL and testbench
=============================

DIV_REPSUB -- requirements
Module: div_repsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator; sampled on the start-accept edge.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator; sampled on the start-accept edge.
REQ-007 The block SHALL have port quotient, output, WIDTH bits: registered result.
REQ-008 The block SHALL have port remainder, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port busy, output, 1 bit: high while state is CALC.
REQ-010 The block SHALL have port done, output, 1 bit: high while state is DONE.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high in DONE when the captured divisor was 0.

Function
REQ-012 The block SHALL divide by repeated subtraction, the inverse of the team's repeated-addition multiplier, with the same start/done handshake style.
REQ-013 The FSM SHALL have exactly three states, IDLE, CALC and DONE, with registered state and Moore outputs busy and done.
REQ-014 IDLE or DONE with start=1 and divisor!=0 SHALL, on one edge, load R<=dividend, D<=divisor and Q<=0, clear div_by_zero, and go to CALC.
REQ-015 IDLE or DONE with start=1 and divisor==0 SHALL, on one edge, load Q<=all-ones and R<=dividend, set div_by_zero, and go to DONE.
REQ-016 In CALC, on each edge where R>=D, the block SHALL apply R<=R-D and Q<=Q+1 and stay in CALC.
REQ-017 In CALC, on the edge where R<D, the block SHALL leave R and Q unchanged and go to DONE.
REQ-018 Latency SHALL be fixed: for a nonzero divisor, done rises after edge Q+2, counting the start-accept edge as edge 1.
REQ-019 Latency for a zero divisor SHALL be one edge after start-accept.
REQ-020 In CALC, start, dividend and divisor SHALL be ignored; no restart and no abort.
REQ-021 DONE SHALL hold done, quotient, remainder and div_by_zero stable until a new start is accepted or reset occurs.
REQ-022 DONE with start=0 SHALL remain in DONE; there is no return to IDLE except by reset.
REQ-023 quotient SHALL equal Q and remainder SHALL equal R at all times, with no separate output register.
REQ-024 Subtraction and comparison SHALL be WIDTH-bit unsigned; R never underflows because subtraction occurs only when R>=D.
REQ-025 The Q counter SHALL be WIDTH bits and never wraps; the worst case is dividend=2^WIDTH-1 with divisor=1, giving Q=2^WIDTH-1.
REQ-026 Boundary case dividend<divisor SHALL take exactly one CALC cycle and give Q=0, R=dividend.
REQ-027 Boundary case dividend=0 with divisor!=0 SHALL give Q=0, R=0.
REQ-028 Boundary case dividend=divisor SHALL give Q=1, R=0.

Reset
REQ-029 While rst_n=0, the block SHALL, asynchronously and regardless of clk: set state=IDLE; clear Q, R, D and div_by_zero; drive busy=0 and done=0.
REQ-030 Reset asserted mid-CALC SHALL abort the division, and no partial result SHALL remain visible.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-032 A shared package SHALL hold the state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b10) and the default WIDTH.
REQ-033 The datapath SHALL be one sub-module, div_datapath, holding R, D, Q, the subtractor and the comparator.
REQ-034 div_datapath SHALL take load, step and zero controls and return a ge (R>=D) flag.
REQ-035 div_repsub SHALL contain the control FSM and instantiate div_datapath.
REQ-036 No delays SHALL be used in the RTL; all timing SHALL be purely edge-driven.

Verification
REQ-037 Directed test, WIDTH=16, dividend=13, divisor=4, start pulsed for 1 cycle: busy for 4 cycles; done after edge 5; quotient=3, remainder=1, div_by_zero=0.
REQ-038 Directed test: dividend=7, divisor=0: done after edge 1; quotient=16'hFFFF, remainder=7, div_by_zero=1.
REQ-039 Directed test: dividend=5, divisor=9: one CALC cycle; quotient=0, remainder=5.
REQ-040 Directed test: start 100/10, then hold start=1 with new operands 50/25 during CALC: new operands ignored; first result quotient=10, remainder=0.
REQ-041 Directed test: next start in DONE accepted; second result quotient=2, remainder=0.
REQ-042 Directed test: rst_n pulsed low mid-CALC of 1000/3, between clock edges: busy, done, quotient and remainder 0 immediately; then 9/3 gives quotient=3, remainder=0.
REQ-043 Directed test, WIDTH=8: dividend=255, divisor=1: quotient=255, remainder=0, done after edge 257, no wrap.

Source files
------------

// File: rtl/div_repsub_pkg.sv
// Shared definitions for the repeated-subtraction divider.
package div_repsub_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: remainder/divisor/quotient registers, subtractor and R>=D compare.
import div_repsub_pkg::*;

module div_datapath #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             zero_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ge_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH-1:0] r_q, d_q, q_q;

  assign ge_o = (r_q >= d_q);
  assign q_o  = q_q;
  assign r_o  = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else if (zero_i) begin
      // Divide-by-zero result: saturated quotient, dividend passed through.
      r_q <= dividend_i;
      d_q <= divisor_i;
      q_q <= '1;
    end else if (load_i) begin
      r_q <= dividend_i;
      d_q <= divisor_i;
      q_q <= '0;
    end else if (step_i) begin
      r_q <= r_q - d_q;
      q_q <= q_q + 1'b1;
    end
  end

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction with start/done handshake.
import div_repsub_pkg::*;

module div_repsub #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t state_q;
  logic   busy_q, done_q, dbz_q;
  logic   accept, dz, load, step, zero, ge;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign dz     = (divisor == '0);
  assign load   = accept && !dz;
  assign zero   = accept && dz;
  assign step   = (state_q == CALC) && ge;

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .zero_i     (zero),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .ge_o       (ge),
    .q_o        (quotient),
    .r_o        (remainder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (dz) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              dbz_q   <= 1'b0;
            end
          end
        end
        CALC: begin
          // Inputs are ignored here; the only exit is R<D.
          if (!ge) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_repsub.sv
// Directed bench for div_repsub: 16-bit and 8-bit instances.
module tb_div_repsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic [15:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  logic        start8 = 1'b0;
  logic [7:0]  dividend8 = '0, divisor8 = '0;
  logic [7:0]  quotient8, remainder8;
  logic        busy8, done8, dbz8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_repsub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  div_repsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .quotient(quotient8), .remainder(remainder8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8)
  );

  // Pulse start for one edge, then count busy samples and the edge done rises after.
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output int done_edge, output int busy_cnt);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    done_edge = -1; busy_cnt = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_edge = k; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int de, bc;
    run16(16'd13, 16'd4, de, bc);
    n_chk++;
    if (de !== 5 || bc !== 4) begin
      n_fail++; $display("FAIL basic_latency: done_edge=%0d busy=%0d, want 5/4", de, bc);
    end
    n_chk++;
    if (quotient !== 16'd3 || remainder !== 16'd1 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: q=%0d r=%0d dbz=%b, want 3/1/0",
                         quotient, remainder, div_by_zero);
    end
    // Results hold in DONE while inputs wander and start stays low.
    dividend = 16'd999; divisor = 16'd7;
    repeat (3) @(negedge clk);
    n_chk++;
    if (!done || busy || quotient !== 16'd3 || remainder !== 16'd1) begin
      n_fail++; $display("FAIL done_hold: done=%b busy=%b q=%0d r=%0d, want 1/0/3/1",
                         done, busy, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int de, bc;
    run16(16'd7, 16'd0, de, bc);
    n_chk++;
    if (de !== 1 || bc !== 0) begin
      n_fail++; $display("FAIL dz_latency: done_edge=%0d busy=%0d, want 1/0", de, bc);
    end
    n_chk++;
    if (quotient !== 16'hFFFF || remainder !== 16'd7 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dz_result: q=%h r=%0d dbz=%b, want ffff/7/1",
                         quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_small();
    int de, bc;
    run16(16'd5, 16'd9, de, bc);
    n_chk++;
    if (de !== 2 || bc !== 1) begin
      n_fail++; $display("FAIL lt_latency: done_edge=%0d busy=%0d, want 2/1", de, bc);
    end
    n_chk++;
    if (quotient !== 16'd0 || remainder !== 16'd5 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL lt_result: q=%0d r=%0d dbz=%b, want 0/5/0",
                         quotient, remainder, div_by_zero);
    end
    run16(16'd0, 16'd6, de, bc);
    n_chk++;
    if (de !== 2 || quotient !== 16'd0 || remainder !== 16'd0) begin
      n_fail++; $display("FAIL zero_dividend: edge=%0d q=%0d r=%0d, want 2/0/0",
                         de, quotient, remainder);
    end
    run16(16'd21, 16'd21, de, bc);
    n_chk++;
    if (de !== 3 || quotient !== 16'd1 || remainder !== 16'd0) begin
      n_fail++; $display("FAIL equal_ops: edge=%0d q=%0d r=%0d, want 3/1/0",
                         de, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int de;
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd10; start = 1'b1;
    @(negedge clk);
    dividend = 16'd50; divisor = 16'd25;
    de = -1;
    for (int k = 2; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin de = k; break; end
    end
    n_chk++;
    if (de !== 12 || quotient !== 16'd10 || remainder !== 16'd0) begin
      n_fail++; $display("FAIL b2b_first: edge=%0d q=%0d r=%0d, want 12/10/0",
                         de, quotient, remainder);
    end
    // start still high: accepted from DONE on the next edge.
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (!busy || done) begin
      n_fail++; $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
    end
    de = -1;
    for (int k = 2; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin de = k; break; end
    end
    n_chk++;
    if (de !== 4 || quotient !== 16'd2 || remainder !== 16'd0) begin
      n_fail++; $display("FAIL b2b_second: edge=%0d q=%0d r=%0d, want 4/2/0",
                         de, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_calc();
    int de, bc;
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, quotient, remainder} !== '0) begin
      n_fail++; $display("FAIL reset_mid_calc: busy=%b done=%b q=%0d r=%0d, want 0",
                         busy, done, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    run16(16'd9, 16'd3, de, bc);
    n_chk++;
    if (de !== 5 || quotient !== 16'd3 || remainder !== 16'd0) begin
      n_fail++; $display("FAIL after_reset: edge=%0d q=%0d r=%0d, want 5/3/0",
                         de, quotient, remainder);
    end
  endtask

  task automatic test_width8_max();
    int de;
    @(negedge clk);
    dividend8 = 8'd255; divisor8 = 8'd1; start8 = 1'b1;
    de = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin de = k; break; end
    end
    n_chk++;
    if (de !== 257 || quotient8 !== 8'd255 || remainder8 !== 8'd0 || dbz8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_max: edge=%0d q=%0d r=%0d dbz=%b, want 257/255/0/0",
                         de, quotient8, remainder8, dbz8);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_small();
    test_back_to_back();
    test_reset_mid_calc();
    test_width8_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
